rom_loader: RTL



---
 rtl/genesis_loader_pkg.sv | 30 +++
 rtl/loader_fifo.sv | 56 +++++
 rtl/rom_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/genesis_loader_pkg.sv
// Shared definitions for the cartridge ROM loader: header checksum
// addresses, loader state encoding and the address-mask helper.
package genesis_loader_pkg;

  // Byte address of the big-endian checksum word in the cartridge header.
  localparam logic [31:0] HDR_CKSUM_ADDR = 32'h0000_018E;
  // First byte address that contributes to the header checksum.
  localparam logic [31:0] CKSUM_START    = 32'h0000_0200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Smear the highest set bit downwards: the result is the smallest
  // (2^n)-1 that is >= v.
  function automatic logic [31:0] fill_ones(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    r = r | (r >> 1);
    r = r | (r >> 2);
    r = r | (r >> 4);
    r = r | (r >> 8);
    r = r | (r >> 16);
    return r;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Single-clock show-ahead FIFO. DEPTH must be a power of two. The head
// entry is presented on dout whenever the FIFO is non-empty. A flush
// empties the FIFO and blocks any push or pop in the same cycle.
module loader_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam logic [PW:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW:0] FULL_CNT = {1'b1, {PW{1'b0}}};

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = mem[rd_ptr[PW-1:0]];

  // Pointer update; reset and flush both return to the empty state.
  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/rom_loader.sv
// Cartridge image loader: buffers HPS download words, byte-swaps them to
// big-endian and writes them to DDR3 through a toggle req/ack port.
// Reports image size, address mask and header checksum on completion.
// Optional feature macro: LOADER_CHECKSUM_EN (header checksum tracking).
module rom_loader
  import genesis_loader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 25
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [15:0]   dl_data,
  output logic          dl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic          mem_we_req,
  input  logic          mem_we_ack,
  output logic [AW-1:0] rom_size,
  output logic [AW-1:0] rom_mask,
  output logic          load_done,
  output logic [15:0]   cksum_calc,
  output logic          cksum_ok
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = AW + 16;

  logic          active_q;
  logic          rise;
  logic          fall;
  logic          flush;
  logic          port_idle;
  logic          push_ok;
  logic          issue;
  logic [15:0]   swapped;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  int            occ_next;
  logic [AW-1:0] max_addr;
  logic [AW-1:0] mask_calc;
  state_t        state;
  state_t        state_nxt;
  logic          done_fire;

  // ---------------------------------------------------------------------
  // Download side
  // ---------------------------------------------------------------------

  // dl_active edge detector; reset forces a fresh rise if it is held high.
  always_ff @(posedge clk_sys) begin
    if (reset) active_q <= 1'b0;
    else       active_q <= dl_active;
  end

  assign rise  = dl_active & ~active_q;
  assign fall  = ~dl_active & active_q;
  assign flush = rise;

  // File bytes arrive little-endian; the Genesis bus is big-endian.
  assign swapped  = {dl_data[7:0], dl_data[15:8]};
  assign fifo_din = {dl_addr, swapped};

  // A strobe while full is a protocol violation and is simply dropped.
  // A strobe coinciding with the flush belongs to no load and is dropped.
  assign push_ok   = dl_wr & ~fifo_full & ~flush;
  assign port_idle = (mem_we_req == mem_we_ack);
  assign issue     = port_idle & ~fifo_empty & ~flush;

  loader_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .flush   (flush),
    .push    (push_ok),
    .din     (fifo_din),
    .pop     (issue),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Occupancy as it will be after this clock edge.
  always_comb begin
    occ_next = int'(fifo_count);
    if (push_ok) occ_next = occ_next + 1;
    if (issue)   occ_next = occ_next - 1;
    if (flush)   occ_next = 0;
  end

  // Backpressure with hysteresis: rise two slots early because the HPS may
  // still land one strobe after seeing wait, release once nearly drained.
  always_ff @(posedge clk_sys) begin
    if (reset)                      dl_wait <= 1'b0;
    else if (occ_next >= DEPTH - 2) dl_wait <= 1'b1;
    else if (occ_next <= 1)         dl_wait <= 1'b0;
  end

  // ---------------------------------------------------------------------
  // Memory write port
  // ---------------------------------------------------------------------

  // Issue one write per ack round trip; reset resynchronises req to ack so
  // a request in flight at reset is not seen as a new one.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_we_req <= mem_we_ack;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else if (issue) begin
      mem_we_req <= ~mem_we_req;
      mem_addr   <= fifo_head[FW-1:16];
      mem_din    <= fifo_head[15:0];
    end
  end

  // ---------------------------------------------------------------------
  // Size tracking
  // ---------------------------------------------------------------------

  // Highest byte address accepted in the current load.
  always_ff @(posedge clk_sys) begin
    if (reset || rise)                     max_addr <= '0;
    else if (push_ok && dl_addr > max_addr) max_addr <= dl_addr;
  end

  // rom_size-1 = max_addr+1; widen so the helper works for any AW <= 32.
  assign mask_calc = AW'(fill_ones(32'(max_addr) + 32'd1));

  // ---------------------------------------------------------------------
  // Load sequencing
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a new download always wins, restarting from LOAD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = LOAD;
      LOAD:    if (fall) state_nxt = DRAIN;
      DRAIN: begin
        if (rise)                         state_nxt = LOAD;
        else if (fifo_empty && port_idle) state_nxt = DONE;
      end
      DONE:    state_nxt = rise ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: completion is reported unless a restart preempts it.
  always_comb begin
    done_fire = (state == DONE) && !rise;
  end

  // Completion pulse and latched image geometry.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      load_done <= 1'b0;
      rom_size  <= '0;
      rom_mask  <= '1;
    end else begin
      load_done <= done_fire;
      if (done_fire) begin
        rom_size <= max_addr + AW'(2);
        rom_mask <= mask_calc;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Header checksum
  // ---------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic [15:0] hdr_q;
  logic        ok_q;

  // Sum the body words, capture the header word, compare at completion.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_q <= '0;
      hdr_q <= '0;
      ok_q  <= 1'b1;
    end else if (rise) begin
      sum_q <= '0;
      hdr_q <= '0;
    end else begin
      if (push_ok && 32'(dl_addr) >= CKSUM_START) sum_q <= sum_q + swapped;
      if (push_ok && 32'(dl_addr) == HDR_CKSUM_ADDR) hdr_q <= swapped;
      if (done_fire) ok_q <= (sum_q == hdr_q);
    end
  end

  assign cksum_calc = sum_q;
  assign cksum_ok   = ok_q;
`else
  assign cksum_calc = 16'h0000;
  assign cksum_ok   = 1'b1;
`endif

endmodule
